// File: rtl/cpu_control_pkg.sv
// Shared definitions for the 8-bit CPU sequencer: ALU opcodes, instruction layout, modes, states.
// Optional build macro used by cpu_control: CPU_OVERFLOW_TRAP_EN.
package cpu_control_pkg;

    localparam logic TRUE = 1'b1;

    typedef enum logic [4:0] {
        ALU_NOP = 5'd0,
        ALU_UAD = 5'd1,
        ALU_USB = 5'd2,
        ALU_UML = 5'd3,
        ALU_UDV = 5'd4,
        ALU_AND = 5'd5,
        ALU_OR  = 5'd6,
        ALU_XOR = 5'd7,
        ALU_SHL = 5'd8,
        ALU_SHR = 5'd9,
        ALU_EQ  = 5'd10,
        ALU_LT  = 5'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        MODE_RR  = 2'b00,
        MODE_RI  = 2'b01,
        MODE_BR  = 2'b10,
        MODE_HLT = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    // Field order here is the bit layout of the 24-bit word, MSB first.
    typedef struct packed {
        logic [4:0] op;    // [23:19]
        mode_e      mode;  // [18:17]
        logic [2:0] rd;    // [16:14]
        logic [2:0] ra;    // [13:11]
        logic [2:0] rb;    // [10:8]
        logic [7:0] imm;   // [7:0]
    } instr_t;

    function automatic logic is_alu_mode(input mode_e m);
        return (m == MODE_RR) || (m == MODE_RI);
    endfunction

endpackage

// File: rtl/cpu_control_regfile.sv
// cpu_regfile: NUM_REGS x 8-bit register file, two asynchronous read ports and one synchronous write port.
// Indices at or above NUM_REGS read as zero and ignore writes.
module cpu_control_regfile #(
    parameter int NUM_REGS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] ra_addr,
    input  logic [2:0] rb_addr,
    output logic [7:0] ra_data,
    output logic [7:0] rb_data,
    input  logic       we,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] r0_data
);

    // Storage is sized for the full 3-bit index space; entries past NUM_REGS never leave zero.
    logic [7:0] regs [8];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else if (we && (int'(wr_addr) < NUM_REGS)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign ra_data = (int'(ra_addr) < NUM_REGS) ? regs[ra_addr] : 8'h00;
    assign rb_data = (int'(rb_addr) < NUM_REGS) ? regs[rb_addr] : 8'h00;
    assign r0_data = regs[0];

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/execute/writeback sequencer for the 8-bit CPU; owns pc, register file and sticky status.
// Build option CPU_OVERFLOW_TRAP_EN: arithmetic overflow halts instead of committing the result.
module cpu_control
    import cpu_control_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int PC_W     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [23:0]     imem_data,
    output logic [4:0]      alu_op,
    output logic [7:0]      operand_a,
    output logic [7:0]      operand_b,
    input  logic [7:0]      alu_result,
    input  logic            shift_overflow,
    input  logic            arithmetic_overflow,
    output logic [PC_W-1:0] pc,
    output logic [1:0]      status,
    output logic [7:0]      r0_out,
    output logic            halted
);

    state_e     state, state_nx;
    instr_t     ir;
    logic [7:0] res_q;
    logic       sovf_q, aovf_q;

    logic [7:0] ra_data, rb_data;
    logic       alu_mode;
    logic       trap;
    logic       rf_we;

    assign alu_mode = is_alu_mode(ir.mode);

`ifdef CPU_OVERFLOW_TRAP_EN
    assign trap = alu_mode && aovf_q;
`else
    assign trap = 1'b0;
`endif

    assign rf_we = (state == ST_WRITEBACK) && alu_mode && !trap;

    cpu_control_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (ir.ra),
        .rb_addr (ir.rb),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (rf_we),
        .wr_addr (ir.rd),
        .wr_data (res_q),
        .r0_data (r0_out)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (run == TRUE) state_nx = ST_FETCH;
            ST_FETCH:     if (imem_valid) state_nx = ST_DECODE;
            ST_DECODE:    state_nx = (ir.mode == MODE_HLT) ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   state_nx = ST_WRITEBACK;
            ST_WRITEBACK: state_nx = trap ? ST_HALT : ST_FETCH;
            ST_HALT:      state_nx = ST_HALT;
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ir        <= '0;
            pc        <= '0;
            status    <= '0;
            alu_op    <= ALU_NOP;
            operand_a <= '0;
            operand_b <= '0;
            res_q     <= '0;
            sovf_q    <= 1'b0;
            aovf_q    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                ST_FETCH: begin
                    if (imem_valid) ir <= instr_t'(imem_data);
                end
                // Operands are registered here so the ALU sees them stable for all of EXECUTE.
                ST_DECODE: begin
                    alu_op    <= ir.op;
                    operand_a <= ra_data;
                    operand_b <= (ir.mode == MODE_RI) ? ir.imm : rb_data;
                end
                ST_EXECUTE: begin
                    res_q  <= alu_result;
                    sovf_q <= shift_overflow;
                    aovf_q <= arithmetic_overflow;
                end
                ST_WRITEBACK: begin
                    if (alu_mode) begin
                        status <= status | {aovf_q, sovf_q};
                        // A trap leaves pc on the faulting instruction.
                        if (!trap) pc <= pc + PC_W'(1);
                    end else if (ir.mode == MODE_BR) begin
                        pc <= res_q[0] ? PC_W'(ir.imm) : pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control: instruction-level reference model, bench-side ALU and program memory.
module tb_cpu_control;
    import cpu_control_pkg::*;

    logic        clk = 1'b0;
    logic        reset, run, imem_req, imem_valid;
    logic [7:0]  imem_addr, pc, operand_a, operand_b, alu_result, r0_out;
    logic [23:0] imem_data;
    logic [4:0]  alu_op;
    logic        shift_overflow, arithmetic_overflow, halted;
    logic [1:0]  status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_control dut (
        .clk                 (clk),
        .reset               (reset),
        .run                 (run),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_valid          (imem_valid),
        .imem_data           (imem_data),
        .alu_op              (alu_op),
        .operand_a           (operand_a),
        .operand_b           (operand_b),
        .alu_result          (alu_result),
        .shift_overflow      (shift_overflow),
        .arithmetic_overflow (arithmetic_overflow),
        .pc                  (pc),
        .status              (status),
        .r0_out              (r0_out),
        .halted              (halted)
    );

    // ALU behaviour: returns {arith_ovf, shift_ovf, result}.
    function automatic logic [9:0] alu_f(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] sh;
        case (op)
            ALU_UAD: begin s = {1'b0, a} + {1'b0, b}; return {s[8], 1'b0, s[7:0]}; end
            ALU_USB: begin s = {1'b0, a} - {1'b0, b}; return {s[8], 1'b0, s[7:0]}; end
            ALU_UDV: return (b == 8'd0) ? {2'b10, 8'hFF} : {2'b00, a / b};
            ALU_OR:  return {2'b00, a | b};
            ALU_SHL: begin sh = {8'h00, a} << b[2:0]; return {1'b0, |sh[15:8], sh[7:0]}; end
            ALU_EQ:  return {9'd0, a == b};
            ALU_LT:  return {9'd0, a < b};
            default: return 10'd0;
        endcase
    endfunction

    assign {arithmetic_overflow, shift_overflow, alu_result} = alu_f(alu_op, operand_a, operand_b);

    function automatic logic [23:0] mk(input logic [4:0] op, input logic [1:0] mode,
                                       input int rd, input int ra, input int rb, input int imm);
        return {op, mode, 3'(rd), 3'(ra), 3'(rb), 8'(imm)};
    endfunction

    localparam logic [23:0] HLT_W = {5'd0, 2'b11, 17'd0};

    logic [23:0] prog [256];
    int stall_addr = -1;
    int stall_cnt  = 0;

    // Program memory: answers every request at once except for a programmed stall.
    initial begin
        imem_valid = 1'b0;
        imem_data  = '0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1 && int'(imem_addr) == stall_addr && stall_cnt < 5) begin
                imem_valid = 1'b0;
                stall_cnt++;
            end else begin
                imem_valid = (imem_req === 1'b1);
            end
            imem_data = prog[imem_addr];
        end
    end

    // Reference model: architectural state, instruction retires three edges after its fetch is accepted.
    logic [7:0]  m_regs [8];
    logic [7:0]  m_pc;
    logic [1:0]  m_status;
    logic        m_halted, m_idle;
    int          m_cnt;
    logic [23:0] m_ir;

    task automatic m_commit();
        logic [1:0] mode;
        logic [7:0] imm, b;
        logic [9:0] r;
        logic       trap;
        mode = m_ir[18:17];
        imm  = m_ir[7:0];
        b    = (mode == 2'b01) ? imm : m_regs[m_ir[10:8]];
        r    = alu_f(m_ir[23:19], m_regs[m_ir[13:11]], b);
        trap = 1'b0;
`ifdef CPU_OVERFLOW_TRAP_EN
        trap = r[9];
`endif
        if (mode == 2'b10) begin
            m_pc = r[0] ? imm : m_pc + 8'd1;
        end else if (trap) begin
            m_status = m_status | r[9:8];
            m_halted = 1'b1;
        end else begin
            m_regs[m_ir[16:14]] = r[7:0];
            m_status = m_status | r[9:8];
            m_pc = m_pc + 8'd1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
                m_pc = 0; m_status = 0; m_halted = 0; m_idle = 1; m_cnt = 0; m_ir = 0;
            end else if (m_idle) begin
                if (run) m_idle = 0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 2 && m_ir[18:17] == 2'b11) begin
                    m_halted = 1'b1;
                    m_cnt = 0;
                end else if (m_cnt == 0) begin
                    m_commit();
                end
            end else if (!m_halted && imem_valid) begin
                m_ir  = imem_data;
                m_cnt = 3;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every out-of-reset cycle: architectural outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                chk("pc", 32'(pc), 32'(m_pc));
                chk("status", 32'(status), 32'(m_status));
                chk("r0_out", 32'(r0_out), 32'(m_regs[0]));
                chk("halted", 32'(halted), 32'(m_halted));
                chk("imem_req", 32'(imem_req), 32'(!m_idle && !m_halted && m_cnt == 0));
                if (imem_req === 1'b1) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
                if (m_cnt == 2 && !m_halted) begin
                    chk("alu_op", 32'(alu_op), 32'(m_ir[23:19]));
                    chk("operand_a", 32'(operand_a), 32'(m_regs[m_ir[13:11]]));
                    chk("operand_b", 32'(operand_b),
                        32'((m_ir[18:17] == 2'b01) ? m_ir[7:0] : m_regs[m_ir[10:8]]));
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        stall_addr = -1;
        stall_cnt  = 0;
        for (int i = 0; i < 256; i++) prog[i] = HLT_W;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_pc(input logic [7:0] t, input int maxc);
        int n = 0;
        while (pc !== t && n < maxc) begin @(negedge clk); n++; end
        chk("wait_pc", 32'(pc), 32'(t));
    endtask

    task automatic wait_halt(input int maxc);
        int n = 0;
        while (halted !== 1'b1 && n < maxc) begin @(negedge clk); n++; end
        chk("wait_halt", 32'(halted), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        @(negedge clk);

        // Phase A: immediate add, branches, fetch stall, halt.
        do_reset();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_opa", 32'(operand_a), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        prog[8'h00] = mk(ALU_UAD, 2'b01, 1, 0, 0, 5);
        prog[8'h01] = mk(ALU_OR,  2'b01, 0, 1, 0, 0);
        prog[8'h02] = mk(ALU_USB, 2'b01, 1, 0, 0, 2);
        prog[8'h03] = mk(ALU_USB, 2'b01, 2, 0, 0, 2);
        prog[8'h04] = mk(ALU_EQ,  2'b10, 0, 1, 2, 8'h40);
        prog[8'h40] = mk(ALU_UAD, 2'b01, 2, 2, 0, 1);
        prog[8'h41] = mk(ALU_EQ,  2'b10, 0, 1, 2, 8'h10);
        prog[8'h42] = mk(ALU_OR,  2'b00, 0, 1, 2, 0);
        stall_addr  = 8'h43;
        pulse_run();
        repeat (3) @(negedge clk);
        chk("add_pc_before", 32'(pc), 32'd0);
        @(negedge clk);
        chk("add_pc_latency", 32'(pc), 32'd1);
        chk("add_status", 32'(status), 32'd0);
        wait_pc(8'h02, 20);
        chk("add_r0", 32'(r0_out), 32'd5);
        wait_pc(8'h40, 40);
        wait_pc(8'h43, 40);
        chk("br_r0", 32'(r0_out), 32'd7);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", 32'(imem_req), 32'd1);
            chk("stall_addr", 32'(imem_addr), 32'h43);
            @(negedge clk);
        end
        wait_halt(20);
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("halt_pc", 32'(pc), 32'h43);
        end
        run = 1'b0;
        chk("halt_flag", 32'(halted), 32'd1);

        // Phase B: unsigned overflow, sticky across NOPs.
        do_reset();
        prog[0] = mk(ALU_UAD, 2'b01, 1, 0, 0, 200);
        prog[1] = mk(ALU_UAD, 2'b01, 2, 1, 0, 100);
        prog[2] = mk(ALU_NOP, 2'b00, 3, 0, 0, 0);
        prog[3] = mk(ALU_NOP, 2'b00, 3, 0, 0, 0);
        prog[4] = mk(ALU_NOP, 2'b00, 3, 0, 0, 0);
        prog[5] = mk(ALU_OR,  2'b01, 0, 2, 0, 0);
        pulse_run();
        wait_halt(60);
`ifdef CPU_OVERFLOW_TRAP_EN
        chk("ovf_trap_pc", 32'(pc), 32'd1);
        chk("ovf_trap_r0", 32'(r0_out), 32'd0);
`else
        chk("ovf_pc", 32'(pc), 32'd6);
        chk("ovf_r0", 32'(r0_out), 32'd44);
`endif
        chk("ovf_status", 32'(status), 32'b10);

        // Phase C: divide by zero into r0.
        do_reset();
        prog[0] = mk(ALU_UAD, 2'b01, 0, 0, 0, 9);
        prog[1] = mk(ALU_UDV, 2'b01, 0, 2, 0, 0);
        pulse_run();
        wait_halt(40);
`ifdef CPU_OVERFLOW_TRAP_EN
        chk("div0_pc", 32'(pc), 32'd1);
        chk("div0_r0", 32'(r0_out), 32'd9);
`else
        chk("div0_pc", 32'(pc), 32'd2);
        chk("div0_r0", 32'(r0_out), 32'hFF);
`endif
        chk("div0_status", 32'(status), 32'b10);

        // Phase D: reset while a write to r3 is in EXECUTE.
        do_reset();
        prog[0] = mk(ALU_UAD, 2'b01, 3, 0, 0, 8'h7F);
        pulse_run();
        begin
            int n = 0;
            while (m_cnt != 2 && n < 20) begin @(negedge clk); n++; end
            chk("mid_reach_exec", 32'(m_cnt), 32'd2);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_pc", 32'(pc), 32'd0);
        chk("mid_req", 32'(imem_req), 32'd0);
        chk("mid_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        prog[0] = mk(ALU_OR, 2'b01, 0, 3, 0, 0);
        @(negedge clk);
        pulse_run();
        wait_halt(40);
        chk("mid_r3", 32'(r0_out), 32'd0);
        chk("mid_end_pc", 32'(pc), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
